uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmit engine among `NUM_REQ` byte-stream requesters. It accepts bytes over a valid/ready handshake and holds the grant for a multi-byte packet until `req_last` or a burst limit. It launches each byte with a one-cycle `tx_start` pulse and paces transfers on the engine's `tx_busy`/`tx_done`. It sits between the system-side message sources and the UART TX/baud-tick datapath.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 8: byte width.
- `MAX_BURST`, default 16: maximum bytes per grant before forced re-arbitration, 1..255.

- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `req_valid` input `NUM_REQ`: per-requester byte valid.
- `req_data` input `NUM_REQ*DATA_W`: requester i occupies bits `[i*DATA_W +: DATA_W]`.
- `req_last` input `NUM_REQ`: marks the final byte of a packet. Sampled with the accepted byte.
- `req_ready` output `NUM_REQ`: accept strobe. At most one bit is high.
- `grant` output `NUM_REQ`: one-hot current owner. All zeros when idle.
- `tx_data` output `DATA_W`: byte presented to the TX engine. Registered.
- `tx_start` output 1: one-cycle launch pulse to the TX engine.
- `tx_busy` input 1: TX engine is shifting a frame.
- `tx_done` input 1: one-cycle pulse at the end of the stop bit.

## Operation
- States: IDLE, SEND, WAIT.
- **IDLE**
  - If any `req_valid` is high, the round-robin pick registers `grant`. The search starts at index `ptr+1` and wraps modulo `NUM_REQ`.
  - Clear `burst_cnt`, then go to SEND.
  - If no request is pending, stay in IDLE with `grant`=0.
- **SEND**
  - `req_ready[g] = req_valid[g] & !tx_busy` (combinational). All other ready bits are 0.
  - On a handshake:
    - Register `tx_data` from `req_data[g]`.
    - Capture `last_q = req_last[g] | (burst_cnt == MAX_BURST-1)`.
    - Increment `burst_cnt`.
    - Pulse `tx_start` on the next cycle, then go to WAIT.
  - If `req_valid[g]` is low while `tx_busy` is low, release the grant:
    - Set `ptr` to g, clear `grant`, go to IDLE.
    - The abandoned packet is the requester's problem; no deadlock is possible.
- **WAIT**
  - Hold until `tx_done`.
  - Then, if `last_q` is set: set `ptr` to g, clear `grant`, go to IDLE.
  - Otherwise return to SEND with the grant kept.
- `tx_done` or `tx_busy` activity outside WAIT is ignored for state purposes. `tx_busy` still gates `req_ready`.
- Only one byte is ever in flight. No buffering beyond the `tx_data` register.
- `burst_cnt` has width `clog2(MAX_BURST+1)` and never wraps, because the limit forces release.
- Reset values:
  - `grant`=0, `req_ready`=0, `tx_start`=0, `tx_data`=0.
  - `ptr`=`NUM_REQ-1`, so requester 0 wins first.
  - state IDLE, `burst_cnt`=0, `last_q`=0.
- Reset mid-operation forces all outputs to their reset values immediately. The TX engine shares `rst`, so no in-flight frame is tracked.

## Timing
- Request valid in IDLE at cycle N:
  - `grant` is valid at N+1.
  - `req_ready` is high at N+1 if `tx_busy` is low.
  - `tx_start` pulses at N+2, with `tx_data` stable from N+2 until the next accept.
- `tx_done` at cycle M:
  - Same owner, not last: `req_ready` can assert again at M+1.
  - After release: the next grant is at M+2 (M+1 IDLE, M+2 SEND).
- `tx_start` is never high for two consecutive cycles. It is never asserted while the state is WAIT with a frame outstanding.
- Simultaneous `req_valid` from all requesters: grants rotate 0,1,2,3,0… with one packet each.

## Structure
- Shared package/header `uart_pkg`:
  - state encodings `ST_IDLE`=2'd0, `ST_SEND`=2'd1, `ST_WAIT`=2'd2;
  - default `DATA_W`.
- One sub-module, `uart_rr_pick`: combinational rotate-priority picker. Inputs are request vector and `ptr`; output is one-hot grant plus `any` flag.
- The FSM, counters and handshake logic stay in `uart_tx_arbiter`.

## Test plan
- **Reset, single byte.**
  - Stimulus: reset, then req 2 valid with 0xA5 and last=1.
  - Required: `grant`=4'b0100 one cycle later; `req_ready[2]` pulse; `tx_start` pulse with `tx_data`=0xA5.
  - Required: after `tx_done`, `grant`=0.
- **Fairness.**
  - Stimulus: all four requesters valid continuously with 1-byte packets.
  - Required: `tx_start` order 0,1,2,3,0,1, with no requester skipped or repeated.
- **Packet hold.**
  - Stimulus: req 1 sends 3 bytes 0x10,0x11,0x12 (last on 0x12) while req 0 is also valid.
  - Required: all three bytes go out before `grant` moves to 0.
- **Burst limit.**
  - Stimulus: `MAX_BURST`=4; req 3 streams 6 bytes with no last; req 0 valid.
  - Required: after 4 bytes `grant` switches to 0; req 3 resumes later.
- **Busy and early drop.**
  - Stimulus: `tx_busy` held high in SEND.
  - Required: `req_ready` stays 0 and no `tx_start` occurs.
  - Stimulus: requester drops valid mid-packet.
  - Required: grant released within 1 cycle.
- **Reset mid-frame.**
  - Stimulus: assert `rst` during WAIT.
  - Required: `grant`/`tx_start`/`req_ready`=0 asynchronously; after release the first grant goes to requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
// Contents: arbiter FSM state encoding and the default byte width.
package uart_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam int unsigned DATA_W_DEF = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker.
// Ports:
//   req  - request vector, one bit per requester
//   ptr  - index of the last owner; the search starts at ptr+1 and wraps
//   gnt  - one-hot winner (all zeros when no request is pending)
//   any  - high when at least one request is pending
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               any
);

    logic [PTR_W-1:0] idx;

    // Walk ptr+1, ptr+2, ... ptr+NUM_REQ (mod NUM_REQ); first hit wins
    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = PTR_W'((32'(ptr) + i) % NUM_REQ);
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX engine among NUM_REQ byte streams.
// A grant is held for a whole packet (until req_last) or MAX_BURST bytes.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   req_valid/data/last   - per-requester byte stream (data packed i*DATA_W)
//   req_ready             - combinational accept strobe, at most one bit high
//   grant                 - registered one-hot owner, zero when idle
//   tx_data, tx_start     - registered byte and one-cycle launch pulse
//   tx_busy, tx_done      - TX engine status and end-of-frame pulse
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    input  logic                      tx_done
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic [CNT_W-1:0]   burst_cnt;
    logic               last_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic               pick_any;
    logic [PTR_W-1:0]   pick_idx;

    logic               sel_valid;
    logic               sel_last;
    logic [DATA_W-1:0]  sel_data;
    logic               accept;
    logic               drop;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    // Binary index of the picker's winner, kept alongside the one-hot grant
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) pick_idx = PTR_W'(i);
        end
    end

    // Current owner's request lane
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == PTR_W'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign accept = (state == ST_SEND) && sel_valid && !tx_busy;
    assign drop   = (state == ST_SEND) && !sel_valid && !tx_busy;

    // Only the owner may see ready, and only while the engine is free
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (owner == PTR_W'(i));
        end
    end

    // Arbitration FSM with registered grant and TX launch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant     <= '0;
            owner     <= '0;
            ptr       <= PTR_W'(NUM_REQ - 1);
            burst_cnt <= '0;
            last_q    <= 1'b0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    burst_cnt <= '0;
                    if (pick_any) begin
                        grant <= pick_gnt;
                        owner <= pick_idx;
                        state <= ST_SEND;
                    end else begin
                        grant <= '0;
                    end
                end
                ST_SEND: begin
                    if (accept) begin
                        tx_data   <= sel_data;
                        // Burst limit forces the same release path as req_last
                        last_q    <= sel_last || (burst_cnt == CNT_W'(MAX_BURST - 1));
                        burst_cnt <= burst_cnt + CNT_W'(1);
                        tx_start  <= 1'b1;
                        state     <= ST_WAIT;
                    end else if (drop) begin
                        ptr   <= owner;
                        grant <= '0;
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        if (last_q) begin
                            ptr   <= owner;
                            grant <= '0;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_SEND;
                        end
                    end
                end
                default: begin
                    grant <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small TX engine stand-in.
module tb_uart_tx_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned MB = 4;

    localparam logic [11:0] EXP_FAIR  [6] = '{12'h130, 12'h231, 12'h432, 12'h833, 12'h130, 12'h231};
    localparam logic [11:0] EXP_HOLD  [4] = '{12'h210, 12'h211, 12'h212, 12'h155};
    localparam logic [11:0] EXP_BURST [7] = '{12'h860, 12'h861, 12'h862, 12'h863, 12'h170, 12'h864, 12'h865};

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    grant;
    logic [DW-1:0]   tx_data;
    logic            tx_start;
    logic            tx_busy;
    logic            tx_done;

    logic            eng_busy;
    logic            eng_done;
    logic [2:0]      eng_cnt;
    logic            force_busy;

    int              n_assert  = 0;
    int              n_fail    = 0;
    int              dbl_start = 0;
    logic            prev_start = 1'b0;
    logic [11:0]     txq [$];

    always #5 clk = ~clk;

    assign tx_busy = eng_busy | force_busy;
    assign tx_done = eng_done;

    uart_tx_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    // TX engine stand-in: busy for a few cycles after tx_start, then a done pulse
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_busy <= 1'b0;
            eng_done <= 1'b0;
            eng_cnt  <= 3'd0;
        end else begin
            eng_done <= 1'b0;
            if (eng_busy) begin
                if (eng_cnt == 3'd0) begin
                    eng_busy <= 1'b0;
                    eng_done <= 1'b1;
                end else begin
                    eng_cnt <= eng_cnt - 3'd1;
                end
            end else if (tx_start) begin
                eng_busy <= 1'b1;
                eng_cnt  <= 3'd3;
            end
        end
    end

    // Log every launch as {grant, tx_data}; count back-to-back pulses
    always @(negedge clk) begin
        if (!rst && tx_start) begin
            txq.push_back({grant, tx_data});
            if (prev_start) dbl_start++;
        end
        prev_start = tx_start & !rst;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic v, input logic [DW-1:0] d, input logic l);
        req_valid[r]          = v;
        req_data[r*DW +: DW]  = d;
        req_last[r]           = l;
    endtask

    // Present a byte and hold it until the arbiter accepts it
    task automatic push(input int r, input logic [DW-1:0] d, input logic l, input string tag);
        bit seen;
        seen = 1'b0;
        set_req(r, 1'b1, d, l);
        #1;
        for (int i = 0; i < 200; i++) begin
            if (req_ready[r]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        check(tag, 32'(seen), 32'd1);
        @(negedge clk); #1;
    endtask

    task automatic wait_grant(input logic [N-1:0] g, input string tag);
        for (int i = 0; i < 200; i++) begin
            if (grant === g) break;
            @(negedge clk); #1;
        end
        check(tag, 32'(grant), 32'(g));
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        req_last   = '0;
        req_data   = '0;
        force_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int busy_rdy;
        int busy_st;
        bit done_seen;

        // Reset state
        do_reset();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_data",  32'(tx_data), 32'd0);

        // Single byte from requester 2
        txq.delete();
        set_req(2, 1'b1, 8'hA5, 1'b1);
        @(negedge clk); #1;
        check("single_grant", 32'(grant), 32'h4);
        check("single_ready", 32'(req_ready), 32'h4);
        @(negedge clk); #1;
        check("single_start", 32'(tx_start), 32'd1);
        check("single_data",  32'(tx_data), 32'hA5);
        check("single_ready_wait", 32'(req_ready), 32'd0);
        set_req(2, 1'b0, 8'h00, 1'b0);
        @(negedge clk); #1;
        check("single_start_pulse", 32'(tx_start), 32'd0);
        wait_grant(4'b0000, "single_release");
        check("single_count", 32'(txq.size()), 32'd1);

        // Fairness: all requesters valid with one-byte packets
        do_reset();
        txq.delete();
        for (int r = 0; r < 4; r++) set_req(r, 1'b1, 8'(8'h30 + r), 1'b1);
        for (int i = 0; i < 400; i++) begin
            if (txq.size() >= 6) break;
            @(negedge clk); #1;
        end
        req_valid = '0;
        wait_grant(4'b0000, "fair_idle");
        check("fair_count", 32'(txq.size()), 32'd6);
        for (int k = 0; k < 6; k++) check($sformatf("fair_%0d", k), 32'(txq[k]), 32'(EXP_FAIR[k]));

        // Packet hold: requester 1 keeps the grant for 3 bytes
        txq.delete();
        set_req(1, 1'b1, 8'h10, 1'b0);
        wait_grant(4'b0010, "hold_grant");
        set_req(0, 1'b1, 8'h55, 1'b1);
        push(1, 8'h10, 1'b0, "hold_b0");
        push(1, 8'h11, 1'b0, "hold_b1");
        push(1, 8'h12, 1'b1, "hold_b2");
        set_req(1, 1'b0, 8'h00, 1'b0);
        push(0, 8'h55, 1'b1, "hold_r0");
        set_req(0, 1'b0, 8'h00, 1'b0);
        wait_grant(4'b0000, "hold_idle");
        check("hold_count", 32'(txq.size()), 32'd4);
        for (int k = 0; k < 4; k++) check($sformatf("hold_%0d", k), 32'(txq[k]), 32'(EXP_HOLD[k]));

        // Burst limit: requester 3 streams without last, requester 0 waiting
        txq.delete();
        set_req(3, 1'b1, 8'h60, 1'b0);
        set_req(0, 1'b1, 8'h70, 1'b1);
        push(3, 8'h60, 1'b0, "burst_b0");
        push(3, 8'h61, 1'b0, "burst_b1");
        push(3, 8'h62, 1'b0, "burst_b2");
        push(3, 8'h63, 1'b0, "burst_b3");
        push(3, 8'h64, 1'b0, "burst_b4");
        set_req(0, 1'b0, 8'h00, 1'b0);
        push(3, 8'h65, 1'b0, "burst_b5");
        set_req(3, 1'b0, 8'h00, 1'b0);
        wait_grant(4'b0000, "burst_idle");
        check("burst_count", 32'(txq.size()), 32'd7);
        for (int k = 0; k < 7; k++) check($sformatf("burst_%0d", k), 32'(txq[k]), 32'(EXP_BURST[k]));

        // Busy held high in SEND: no ready, no launch
        force_busy = 1'b1;
        set_req(2, 1'b1, 8'h77, 1'b0);
        @(negedge clk); #1;
        check("busy_grant", 32'(grant), 32'h4);
        busy_rdy = 0;
        busy_st  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (|req_ready) busy_rdy++;
            if (tx_start) busy_st++;
        end
        check("busy_no_ready", 32'(busy_rdy), 32'd0);
        check("busy_no_start", 32'(busy_st), 32'd0);
        check("busy_grant_kept", 32'(grant), 32'h4);
        force_busy = 1'b0;
        push(2, 8'h77, 1'b0, "busy_accept");
        check("busy_start", 32'(tx_start), 32'd1);
        check("busy_data", 32'(tx_data), 32'h77);

        // Early drop mid-packet: grant released one cycle after returning to SEND
        set_req(2, 1'b0, 8'h00, 1'b0);
        done_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tx_done) begin
                done_seen = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        check("drop_done_seen", 32'(done_seen), 32'd1);
        @(negedge clk); #1;
        check("drop_send_grant", 32'(grant), 32'h4);
        @(negedge clk); #1;
        check("drop_release", 32'(grant), 32'd0);

        // Reset during WAIT
        push(1, 8'h99, 1'b1, "mid_accept");
        check("mid_start", 32'(tx_start), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_start", 32'(tx_start), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_data",  32'(tx_data), 32'd0);
        for (int r = 0; r < 4; r++) set_req(r, 1'b1, 8'(8'h40 + r), 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        @(negedge clk); #1;
        check("mid_first_grant", 32'(grant), 32'h1);
        check("mid_first_ready", 32'(req_ready), 32'h1);
        req_valid = '0;

        check("no_double_start", 32'(dbl_start), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
